// File: rtl/phase_accum_tdm.sv
// phase_accum_tdm: time-multiplexed per-channel phase accumulator.
// Scans NUM_CHAN channels round-robin in 2-cycle slots (SELECT, UPDATE),
// advances each channel's phase by the modulated tuning word and emits one
// phase sample per enabled channel per frame.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   scan_en          run channel scan (sampled in IDLE and UPDATE only)
//   note_enable      per-channel gate; a rising edge schedules a phase clear
//   mod_tuning_word  tuning word for the channel selected by curr_note
//   curr_note        one-hot selected channel (zero when idle)
//   acc_en           one-hot 1-cycle strobe during UPDATE
//   phase_out        phase sample of channel phase_chan
//   phase_chan       channel index of phase_out
//   phase_valid      1-cycle pulse qualifying phase_out/phase_chan
//   frame_start      1-cycle pulse with SELECT of channel 0
module phase_accum_tdm #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_CHAN = 16,
  parameter int unsigned CH_W     = $clog2(NUM_CHAN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_en,
  input  logic [NUM_CHAN-1:0] note_enable,
  input  logic [NUM_BITS-1:0] mod_tuning_word,
  output logic [NUM_CHAN-1:0] curr_note,
  output logic [NUM_CHAN-1:0] acc_en,
  output logic [NUM_BITS-1:0] phase_out,
  output logic [CH_W-1:0]     phase_chan,
  output logic                phase_valid,
  output logic                frame_start
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [NUM_CHAN-1:0] sel_d;

  logic [NUM_BITS-1:0] phase_q [NUM_CHAN];
  logic [NUM_CHAN-1:0] note_prev_q;
  logic [NUM_CHAN-1:0] pending_clr_q, pending_clr_d;
  logic [NUM_CHAN-1:0] note_rise;
  logic [NUM_CHAN-1:0] upd_mask;

  logic                upd;
  logic                sel_en;
  logic                sel_clr;
  logic [NUM_BITS-1:0] new_phase;

  logic [NUM_CHAN-1:0] curr_note_q;
  logic [NUM_CHAN-1:0] acc_en_q;
  logic [NUM_BITS-1:0] phase_out_q;
  logic [CH_W-1:0]     phase_chan_q;
  logic                phase_valid_q;
  logic                frame_start_q;

  // Next-state: slot sequencing and channel advance.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_en) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        chan_d  = (chan_q == CH_W'(NUM_CHAN - 1)) ? '0 : chan_q + CH_W'(1);
        state_d = scan_en ? ST_SELECT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sel_d = NUM_CHAN'(1) << chan_d;
  end

  // Phase datapath for the channel in its UPDATE cycle.
  always_comb begin
    upd       = (state_q == ST_UPDATE);
    upd_mask  = upd ? (NUM_CHAN'(1) << chan_q) : '0;
    sel_en    = note_enable[chan_q];
    sel_clr   = pending_clr_q[chan_q];
    note_rise = note_enable & ~note_prev_q;
    new_phase = phase_q[chan_q];
    if (sel_clr) begin
      new_phase = '0;
    end else if (sel_en) begin
      new_phase = phase_q[chan_q] + mod_tuning_word;
    end
    // A rise coinciding with the UPDATE wins, so that clear lands next frame.
    pending_clr_d = (pending_clr_q & ~upd_mask) | note_rise;
  end

  // State and channel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  // Phase registers, note-on history and pending clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHAN; i++) phase_q[i] <= '0;
      note_prev_q   <= '0;
      pending_clr_q <= '0;
    end else begin
      if (upd) phase_q[chan_q] <= new_phase;
      note_prev_q   <= note_enable;
      pending_clr_q <= pending_clr_d;
    end
  end

  // Registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_note_q   <= '0;
      acc_en_q      <= '0;
      frame_start_q <= 1'b0;
      phase_valid_q <= 1'b0;
      phase_out_q   <= '0;
      phase_chan_q  <= '0;
    end else begin
      curr_note_q   <= (state_d != ST_IDLE) ? sel_d : '0;
      acc_en_q      <= (state_d == ST_UPDATE) ? sel_d : '0;
      frame_start_q <= (state_d == ST_SELECT) && (chan_d == '0);
      phase_valid_q <= upd && sel_en;
      if (upd && sel_en) begin
        phase_out_q  <= new_phase;
        phase_chan_q <= chan_q;
      end
    end
  end

  assign curr_note   = curr_note_q;
  assign acc_en      = acc_en_q;
  assign frame_start = frame_start_q;
  assign phase_valid = phase_valid_q;
  assign phase_out   = phase_out_q;
  assign phase_chan  = phase_chan_q;

endmodule
